// File: rtl/dmem_write_buffer.sv
// Data-memory responder with a posted FIFO write buffer in front of a slow word array.
// Loads forward from the youngest matching buffered store; stores stall only when the buffer is full.
module dmem_write_buffer #(
    parameter int DEPTH        = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int WRITE_CYCLES = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dmem_we,
    input  logic                     dmem_re,
    input  logic [31:0]              dmem_addr,
    input  logic [31:0]              dmem_wd,
    output logic [31:0]              dmem_rd,
    output logic                     stall,
    output logic                     misaligned,
    output logic [$clog2(DEPTH):0]   buffer_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CTR_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
    localparam int WORDS = 2 ** ADDR_WIDTH;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CTR_W-1:0] CTR_RELOAD = CTR_W'(WRITE_CYCLES - 1);

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_WAIT
    } drain_state_e;

    drain_state_e            state_q, state_d;
    logic [CTR_W-1:0]        ctr_q, ctr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    misaligned_q, misaligned_d;

    logic [ADDR_WIDTH-1:0]   buf_idx_q  [DEPTH];
    logic [31:0]             buf_data_q [DEPTH];
    logic [31:0]             mem_q      [WORDS];

    logic                    aligned;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    commit;
    logic                    enq;
    logic                    load_ok;
    logic                    rd_hit;
    logic [31:0]             rd_fwd;
    logic [PTR_W-1:0]        slot;

    // Address bits above the word index alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^dmem_addr[31:ADDR_WIDTH+2];

    assign aligned  = (dmem_addr[1:0] == 2'b00);
    assign word_idx = dmem_addr[ADDR_WIDTH+1:2];
    assign commit   = (state_q == DRAIN_WAIT) && (ctr_q == '0);
    assign stall    = dmem_we && aligned && (count_q == FULL_COUNT) && !commit;
    assign enq      = dmem_we && aligned && !stall;
    assign load_ok  = dmem_re && !dmem_we && aligned;

    assign buffer_count = count_q;
    assign misaligned   = misaligned_q;

    // Forwarding: scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        rd_hit  = 1'b0;
        rd_fwd  = '0;
        slot    = '0;
        dmem_rd = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (buf_idx_q[slot] == word_idx)) begin
                rd_hit = 1'b1;
                rd_fwd = buf_data_q[slot];
            end
        end
        if (load_ok) begin
            dmem_rd = rd_hit ? rd_fwd : mem_q[word_idx];
        end
    end

    always_comb begin
        wr_ptr_d     = enq    ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = commit ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q + {{(CNT_W-1){1'b0}}, enq} - {{(CNT_W-1){1'b0}}, commit};
        misaligned_d = misaligned_q || ((dmem_we || dmem_re) && !aligned);
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        case (state_q)
            DRAIN_IDLE: begin
                if (enq) begin
                    state_d = DRAIN_WAIT;
                    ctr_d   = CTR_RELOAD;
                end
            end
            DRAIN_WAIT: begin
                if (commit) begin
                    // A same-cycle enqueue keeps the drain running.
                    if (count_d != '0) begin
                        ctr_d = CTR_RELOAD;
                    end else begin
                        state_d = DRAIN_IDLE;
                    end
                end else begin
                    ctr_d = ctr_q - CTR_W'(1);
                end
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= DRAIN_IDLE;
            ctr_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            misaligned_q <= misaligned_d;
        end
    end

    // NOTE: storage arrays are deliberately not reset; the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (enq) begin
            buf_idx_q[wr_ptr_q]  <= word_idx;
            buf_data_q[wr_ptr_q] <= dmem_wd;
        end
        if (commit) begin
            mem_q[buf_idx_q[rd_ptr_q]] <= buf_data_q[rd_ptr_q];
        end
    end

endmodule
